// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared phase encoding and default 640x480@60 timing constants
package vga_timing_pkg;

  typedef enum logic [1:0] {
    ACTIVE      = 2'd0,
    FRONT_PORCH = 2'd1,
    SYNC        = 2'd2,
    BACK_PORCH  = 2'd3
  } phase_t;

  localparam int COUNT_W = 10;

  localparam int DEF_ACTIVE_COLS   = 640;
  localparam int DEF_H_FRONT_PORCH = 16;
  localparam int DEF_H_SYNC_PULSE  = 96;
  localparam int DEF_H_BACK_PORCH  = 48;
  localparam int DEF_ACTIVE_ROWS   = 480;
  localparam int DEF_V_FRONT_PORCH = 10;
  localparam int DEF_V_SYNC_PULSE  = 2;
  localparam int DEF_V_BACK_PORCH  = 33;

  function automatic int calc_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_timer.sv
// rtl/vga_axis_timer.sv - one raster axis: segment counter plus phase FSM
module vga_axis_timer
  import vga_timing_pkg::*;
#(
  parameter int SEG_ACTIVE = DEF_ACTIVE_COLS,
  parameter int SEG_FP     = DEF_H_FRONT_PORCH,
  parameter int SEG_SYNC   = DEF_H_SYNC_PULSE,
  parameter int SEG_BP     = DEF_H_BACK_PORCH
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_n,
  input  logic                 i_Advance,
  output logic                 o_Wrap,
  output logic [1:0]           o_Phase,
  output logic [COUNT_W-1:0]   o_Count
);

  localparam int TOTAL = calc_total(SEG_ACTIVE, SEG_FP, SEG_SYNC, SEG_BP);

  localparam logic [COUNT_W-1:0] LAST     = COUNT_W'(TOTAL - 1);
  localparam logic [COUNT_W-1:0] END_ACT  = COUNT_W'(SEG_ACTIVE - 1);
  localparam logic [COUNT_W-1:0] END_FP   = COUNT_W'(SEG_ACTIVE + SEG_FP - 1);
  localparam logic [COUNT_W-1:0] END_SYNC = COUNT_W'(SEG_ACTIVE + SEG_FP + SEG_SYNC - 1);

  logic [COUNT_W-1:0] count_q, count_d;
  phase_t             phase_q, phase_d;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      count_q <= LAST;
      phase_q <= BACK_PORCH;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
    end
  end

  // Phase changes are keyed on the last count of each segment, equality only.
  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    o_Wrap  = 1'b0;
    if (i_Advance) begin
      if (count_q == LAST) begin
        count_d = '0;
        phase_d = ACTIVE;
        o_Wrap  = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
        if (count_q == END_ACT) begin
          phase_d = FRONT_PORCH;
        end else if (count_q == END_FP) begin
          phase_d = SYNC;
        end else if (count_q == END_SYNC) begin
          phase_d = BACK_PORCH;
        end
      end
    end
  end

  // Phase is the one being entered on this edge so the top can register flags in step with the count.
  assign o_Phase = phase_d;
  assign o_Count = count_q;

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - free-running VGA timing generator with registered syncs, enable and counters
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int   ACTIVE_COLS   = DEF_ACTIVE_COLS,
  parameter int   H_FRONT_PORCH = DEF_H_FRONT_PORCH,
  parameter int   H_SYNC_PULSE  = DEF_H_SYNC_PULSE,
  parameter int   H_BACK_PORCH  = DEF_H_BACK_PORCH,
  parameter int   ACTIVE_ROWS   = DEF_ACTIVE_ROWS,
  parameter int   V_FRONT_PORCH = DEF_V_FRONT_PORCH,
  parameter int   V_SYNC_PULSE  = DEF_V_SYNC_PULSE,
  parameter int   V_BACK_PORCH  = DEF_V_BACK_PORCH,
  parameter logic SYNC_ACTIVE   = 1'b0
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_En,
  output logic       o_HSync,
  output logic       o_VSync,
  output logic       o_Active,
  output logic [9:0] o_Col_Count,
  output logic [9:0] o_Row_Count,
  output logic       o_Frame_Start
);

  localparam int TOTAL_COLS = calc_total(ACTIVE_COLS, H_FRONT_PORCH, H_SYNC_PULSE, H_BACK_PORCH);
  localparam int TOTAL_ROWS = calc_total(ACTIVE_ROWS, V_FRONT_PORCH, V_SYNC_PULSE, V_BACK_PORCH);

  if (TOTAL_COLS > (1 << COUNT_W)) begin : g_cols_too_wide
    $error("vga_sync_gen: TOTAL_COLS exceeds 10-bit counter range");
  end
  if (TOTAL_ROWS > (1 << COUNT_W)) begin : g_rows_too_wide
    $error("vga_sync_gen: TOTAL_ROWS exceeds 10-bit counter range");
  end

  logic       h_wrap, v_wrap;
  logic [1:0] h_phase_nx, v_phase_nx;

  vga_axis_timer #(
    .SEG_ACTIVE (ACTIVE_COLS),
    .SEG_FP     (H_FRONT_PORCH),
    .SEG_SYNC   (H_SYNC_PULSE),
    .SEG_BP     (H_BACK_PORCH)
  ) u_h_timer (
    .i_Clk     (i_Clk),
    .i_Rst_n   (i_Rst_n),
    .i_Advance (i_En),
    .o_Wrap    (h_wrap),
    .o_Phase   (h_phase_nx),
    .o_Count   (o_Col_Count)
  );

  vga_axis_timer #(
    .SEG_ACTIVE (ACTIVE_ROWS),
    .SEG_FP     (V_FRONT_PORCH),
    .SEG_SYNC   (V_SYNC_PULSE),
    .SEG_BP     (V_BACK_PORCH)
  ) u_v_timer (
    .i_Clk     (i_Clk),
    .i_Rst_n   (i_Rst_n),
    .i_Advance (i_En & h_wrap),
    .o_Wrap    (v_wrap),
    .o_Phase   (v_phase_nx),
    .o_Count   (o_Row_Count)
  );

  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic active_q, active_d;
  logic frame_start_q, frame_start_d;

  // A vertical wrap only happens on an enabled edge into (0,0), so it is exactly the frame-start event.
  always_comb begin
    hsync_d       = (phase_t'(h_phase_nx) == SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync_d       = (phase_t'(v_phase_nx) == SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    active_d      = (phase_t'(h_phase_nx) == ACTIVE) && (phase_t'(v_phase_nx) == ACTIVE);
    frame_start_d = v_wrap;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      hsync_q       <= ~SYNC_ACTIVE;
      vsync_q       <= ~SYNC_ACTIVE;
      active_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign o_HSync       = hsync_q;
  assign o_VSync       = vsync_q;
  assign o_Active      = active_q;
  assign o_Frame_Start = frame_start_q;

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
Free-running VGA timing generator. It produces HSync, VSync, a data-enable and pixel column/row counters from a single pixel clock. It sits at the head of the video pipeline and drives the pattern/pixel logic and the sync-to-count recovery stages downstream. Default timing is 640x480 at 60 Hz with an 800x525 total raster.

Parameters:
ACTIVE_COLS, 640, visible pixels per line
H_FRONT_PORCH, 16, pixels from end of active to HSync assert
H_SYNC_PULSE, 96, HSync width in pixels
H_BACK_PORCH, 48, pixels from HSync deassert to next line
ACTIVE_ROWS, 480, visible lines per frame
V_FRONT_PORCH, 10, lines from end of active to VSync assert
V_SYNC_PULSE, 2, VSync width in lines
V_BACK_PORCH, 33, lines from VSync deassert to next frame
SYNC_ACTIVE, 1'b0, asserted level of both syncs (0 = active-low)
Derived values, not overridable: TOTAL_COLS = sum of the H terms (800); TOTAL_ROWS = sum of the V terms (525).

Ports:
i_Clk  in  1  pixel clock
i_Rst_n  in  1  asynchronous active-low reset
i_En  in  1  count enable; when low, all outputs hold
o_HSync  out  1  horizontal sync, level given by SYNC_ACTIVE
o_VSync  out  1  vertical sync, level given by SYNC_ACTIVE
o_Active  out  1  high when (col < ACTIVE_COLS) and (row < ACTIVE_ROWS)
o_Col_Count  out  10  current column, 0..TOTAL_COLS-1
o_Row_Count  out  10  current row, 0..TOTAL_ROWS-1
o_Frame_Start  out  1  one-cycle pulse when the raster enters (0,0)

Behaviour:
- Reset is asynchronous and active-low; release is synchronous to i_Clk. Reset values:
  - o_Col_Count = TOTAL_COLS-1, o_Row_Count = TOTAL_ROWS-1 (last blanking pixel of a frame).
  - o_HSync = o_VSync = ~SYNC_ACTIVE.
  - o_Active = 0, o_Frame_Start = 0.
- All outputs are registered and mutually consistent: syncs, o_Active and o_Frame_Start always describe the count values presented in the same cycle. There is zero latency between count and flags. Implement by decoding the next count.
- Horizontal phase FSM, advancing only when i_En=1:
  - H_ACTIVE: col 0..639
  - H_FP: col 640..655
  - H_SYNC: col 656..751, o_HSync = SYNC_ACTIVE
  - H_BP: col 752..799
  - At col TOTAL_COLS-1 the column wraps to 0, the FSM returns to H_ACTIVE and the row advances.
- Vertical phase FSM, advancing only on a line wrap:
  - V_ACTIVE: row 0..479
  - V_FP: row 480..489
  - V_SYNC: row 490..491, o_VSync = SYNC_ACTIVE for the whole line, including the H blanking of those lines
  - V_BP: row 492..524
  - At row TOTAL_ROWS-1 with a line wrap, the row wraps to 0.
- o_Frame_Start = 1 for exactly the cycle where col=0 and row=0 are presented. It is 0 while i_En is low, even when the raster is held at (0,0).
- i_En low: counters, FSMs and all outputs hold their values. o_Frame_Start is forced to 0.
- First enabled edge after reset: outputs (0,0), o_Active=1, o_Frame_Start=1.
- Reset mid-frame: outputs return to the reset values immediately, without waiting for a clock edge.
- Width rule: counters are 10 bits. Elaboration fails if TOTAL_COLS > 1024 or TOTAL_ROWS > 1024.
- Phase boundaries are computed from parameters as constants. Comparators use equality on the boundary values only, no magnitude compares on the counters.

Decomposition:
- Package vga_timing_pkg holds:
  - enum phase_t {ACTIVE, FRONT_PORCH, SYNC, BACK_PORCH}
  - default 640x480 constants
  - function computing TOTAL from the four segment lengths
- One sub-module, vga_axis_timer: a parameterised segment counter plus phase FSM with an i_Advance input and o_Wrap/o_Phase/o_Count outputs.
  - Instantiate twice. The H instance has i_Advance = i_En; the V instance has i_Advance = i_En & H wrap.
- The top level does output decode and registration only.

Test Plan:
- Hold reset, then release with i_En=1 -> before release: col=799, row=524, HSync=VSync=1, Active=0. First edge after release: (0,0), Active=1, Frame_Start=1.
- Run one line -> HSync=0 exactly for col 656..751 (96 cycles). Active falls at col 640. Col wraps 799->0 with row 0->1.
- Run full frame -> VSync=0 for rows 490..491 (1600 cycles). Active=0 for rows 480..524. Frame_Start pulses again after exactly 420000 cycles.
- Drop i_En for 10 cycles at col 700, row 5 -> all outputs frozen at (700,5), HSync=0. Resume continues at col 701.
- Drop i_En at (0,0) -> Frame_Start goes low and stays low while held; no second pulse on resume.
- Assert reset at col 300, row 200 -> outputs reach the reset values immediately without waiting for a clock edge; on release the sequence restarts at (0,0).
